// File: rtl/serial_adder.sv
// Digit-serial WIDTH-bit adder: one DIGIT-bit slice plus a registered carry, handshaked by start/ready/done.
// Latency: done pulses in the cycle after edge E0+N, and ready returns after edge E0+N+1 (N = WIDTH/DIGIT).
// Backpressure: start is honoured only while ready is high; requests made while busy are dropped, not queued.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int DG   = (DIGIT < 1) ? 1 : DIGIT;
    localparam int N    = (WIDTH / DG < 1) ? 1 : WIDTH / DG;
    localparam int CLG  = $clog2(N + 1);
    localparam int CW   = (CLG < 1) ? 1 : CLG;

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DG) != 0) begin : g_bad_params
        $error("serial_adder: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] opa, opb, psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb, b_msb;

    logic             load, step, last;
    logic [DG:0]      slice;
    logic [WIDTH+DG-1:0] psum_ext;
    logic [WIDTH-1:0] psum_nxt;

    // One shared slice: the low digit of each operand plus the running carry.
    assign slice    = {1'b0, opa[DG-1:0]} + {1'b0, opb[DG-1:0]} + {{DG{1'b0}}, carry};
    // New digit enters at the MSB end; the concatenation keeps DIGIT==WIDTH legal.
    assign psum_ext = {slice[DG-1:0], psum};
    assign psum_nxt = psum_ext[WIDTH+DG-1:DG];
    assign last     = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (load) begin
            opa   <= a;
            opb   <= b;
            psum  <= '0;
            carry <= c_in;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (step) begin
            opa   <= opa >> DG;
            opb   <= opb >> DG;
            psum  <= psum_nxt;
            carry <= slice[DG];
            cnt   <= cnt + CW'(1);
        end
    end

    // Visible results move only on the final digit edge, so they hold through RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (step && last) begin
            sum   <= psum_nxt;
            c_out <= slice[DG];
            ovf   <= (a_msb == b_msb) && (psum_nxt[WIDTH-1] != a_msb);
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench: directed W16/D4 vectors plus exhaustive W4 runs at DIGIT 1, 2 and 4.
// Stimulus pushes expected results; negedge monitors pop and compare on every done pulse.
module tb_serial_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rst4_n;
    logic        start;
    logic [15:0] a, b;
    logic        c_in;
    logic        ready, done, c_out, ovf;
    logic [15:0] sum;

    int tests;
    int fails;
    int cyc;
    int fin_cnt;
    int main_dones;
    int main_pushes;
    logic [15:0] prev_sum;
    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
        .ready(ready), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Main scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            main_dones++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("c_out", 32'(c_out), 32'(e.c));
                chk("ovf", 32'(ovf), 32'(e.o));
            end
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                          input logic [15:0] es, input logic ec, input logic eo,
                          input bit disturb, input bit abort);
        @(negedge clk);
        chk("ready_idle", 32'(ready), 32'd1);
        a = ta; b = tb2; c_in = tc; start = 1'b1;
        @(posedge clk);                                // E0
        #1 start = 1'b0;
        if (!abort) begin
            q.push_back('{s: es, c: ec, o: eo});
            main_pushes++;
        end
        @(posedge clk);                                // E0+1
        if (disturb) begin
            #1 a = ~ta; b = ~tb2; c_in = ~tc; start = 1'b1;
            @(posedge clk);                            // E0+2
            #1 start = 1'b0;
        end else begin
            @(posedge clk);                            // E0+2
        end
        if (abort) begin
            #1 rst_n = 1'b0;
            #1;
            chk("abort_ready", 32'(ready), 32'd1);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_sum", 32'(sum), 32'd0);
            chk("abort_cout", 32'(c_out), 32'd0);
            repeat (6) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            prev_sum = 16'h0;
        end else begin
            @(negedge clk);
            chk("sum_hold", 32'(sum), 32'(prev_sum));
            chk("ready_busy", 32'(ready), 32'd0);
            @(posedge clk);                            // E0+3
            @(posedge clk);                            // E0+4
            @(negedge clk);
            chk("done_latency", 32'(done), 32'd1);
            @(posedge clk);                            // E0+5
            @(negedge clk);
            chk("ready_latency", 32'(ready), 32'd1);
            chk("done_one_cycle", 32'(done), 32'd0);
            prev_sum = es;
        end
    endtask

    // Exhaustive 4-bit instances, each with its own stimulus, queue and monitor
    for (genvar g = 0; g < 3; g++) begin : g_w4
        localparam int D  = 1 << g;
        localparam int NN = 4 / D;

        logic       start4, c4, ready4, done4, co4, ov4;
        logic [3:0] a4, b4, sum4;
        logic [5:0] expq[$];
        int         dones;
        int         last_cyc;

        serial_adder #(.WIDTH(4), .DIGIT(D)) dut4 (
            .clk(clk), .rst_n(rst4_n), .start(start4), .a(a4), .b(b4), .c_in(c4),
            .ready(ready4), .done(done4), .sum(sum4), .c_out(co4), .ovf(ov4)
        );

        initial begin
            logic [8:0] v;
            logic [4:0] e;
            bit         stuck;
            start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
            dones = 0; last_cyc = -1; stuck = 0;
            @(negedge clk iff rst4_n);
            start4 = 1'b1;
            for (int k = 0; k < 512 && !stuck; k++) begin
                int w;
                w = 0;
                while (!ready4 && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                if (!ready4) begin
                    chk($sformatf("w4d%0d_ready_timeout", D), 32'(ready4), 32'd1);
                    stuck = 1;
                end else begin
                    v = 9'(k);
                    {c4, a4, b4} = v;
                    e = {1'b0, a4} + {1'b0, b4} + {4'b0, c4};
                    expq.push_back({(a4[3] == b4[3]) && (e[3] != a4[3]), e});
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            start4 = 1'b0;
            for (int w = 0; w < 20 && expq.size() != 0; w++) @(negedge clk);
            repeat (10) @(negedge clk);
            chk($sformatf("w4d%0d_pending", D), 32'(expq.size()), 32'd0);
            chk($sformatf("w4d%0d_done_count", D), 32'(dones), 32'd512);
            fin_cnt++;
        end

        always @(negedge clk) begin
            if (rst4_n && done4) begin
                logic [5:0] x;
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL w4d%0d_extra_done: got done=1 expected none (t=%0t)", D, $time);
                end else begin
                    x = expq.pop_front();
                    chk($sformatf("w4d%0d_result", D), 32'({ov4, co4, sum4}), 32'(x));
                end
                if (last_cyc >= 0) chk($sformatf("w4d%0d_spacing", D), 32'(cyc - last_cyc), 32'(NN + 2));
                last_cyc = cyc;
                dones++;
            end
        end
    end

    initial begin
        tests = 0; fails = 0; cyc = 0; fin_cnt = 0;
        main_dones = 0; main_pushes = 0; prev_sum = 16'h0;
        rst_n = 1'b0; rst4_n = 1'b0;
        start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rst4_n = 1'b1;

        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 0);
        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0, 0);
        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1, 0);
        run_op(16'hABCD, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1);
        run_op(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 0);
        repeat (10) @(negedge clk);
        chk("main_done_count", 32'(main_dones), 32'(main_pushes));
        chk("main_pending", 32'(q.size()), 32'd0);

        for (int w = 0; w < 20000 && fin_cnt < 3; w++) @(negedge clk);
        chk("w4_finished", 32'(fin_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
